// File: rtl/video_mux_ctrl_if.sv
// Mode-request and mux-select bundle between the video pipeline and video_mux_ctrl.
interface video_mux_ctrl_if;
  logic       new_frame_in;
  logic       bg_btn_in;
  logic       target_btn_in;
  logic       cmd_valid_in;
  logic [1:0] cmd_bg_in;
  logic [1:0] cmd_target_in;
  logic       cmd_ready_out;
  logic [1:0] bg_out;
  logic [1:0] target_out;
  logic       mode_change_out;
  logic       busy_out;

  modport master (
    output new_frame_in, bg_btn_in, target_btn_in, cmd_valid_in, cmd_bg_in, cmd_target_in,
    input  cmd_ready_out, bg_out, target_out, mode_change_out, busy_out
  );

  modport slave (
    input  new_frame_in, bg_btn_in, target_btn_in, cmd_valid_in, cmd_bg_in, cmd_target_in,
    output cmd_ready_out, bg_out, target_out, mode_change_out, busy_out
  );
endinterface

// File: rtl/video_mux_ctrl.sv
// Frame-synchronous background/overlay mode controller with post-commit test-colour flash.
// Optional macro AUTO_CYCLE_EN: step the background automatically after AUTO_PERIOD_FRAMES idle frames.
module video_mux_ctrl #(
  parameter int FLASH_FRAMES       = 4,
  parameter int AUTO_PERIOD_FRAMES = 120
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  video_mux_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PEND, FLASH} state_e;

  localparam logic [7:0] FLASH_LD = 8'(FLASH_FRAMES);
  localparam logic [1:0] TGT_TEST = 2'b11;

  state_e     state_q, state_d;
  logic [1:0] active_bg_q, active_bg_d;
  logic [1:0] active_tgt_q, active_tgt_d;
  logic [1:0] pend_bg_q, pend_bg_d;
  logic [1:0] pend_tgt_q, pend_tgt_d;
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic [1:0] bg_q, bg_d;
  logic [1:0] tgt_q, tgt_d;
  logic       mc_q, mc_d;

  logic btn, cmd_ready, accept;

  // Overlay code 11 belongs to the flash; the stepping order skips it.
  function automatic logic [1:0] tgt_step(input logic [1:0] t);
    case (t)
      2'b00:   tgt_step = 2'b01;
      2'b01:   tgt_step = 2'b10;
      default: tgt_step = 2'b00;
    endcase
  endfunction

  assign btn       = bus.bg_btn_in | bus.target_btn_in;
  assign cmd_ready = rst_n_in & (state_q != FLASH) & ~bus.new_frame_in & ~btn;
  assign accept    = bus.cmd_valid_in & cmd_ready;

`ifdef AUTO_CYCLE_EN
  localparam logic [15:0] AUTO_LD = 16'(AUTO_PERIOD_FRAMES);
  logic [15:0] idle_cnt_q, idle_cnt_d;
`else
  wire unused_auto = |16'(AUTO_PERIOD_FRAMES);
`endif

  always_comb begin
    state_d      = state_q;
    active_bg_d  = active_bg_q;
    active_tgt_d = active_tgt_q;
    pend_bg_d    = pend_bg_q;
    pend_tgt_d   = pend_tgt_q;
    flash_cnt_d  = flash_cnt_q;
    mc_d         = 1'b0;

    case (state_q)
      IDLE, PEND: begin
        if (!bus.new_frame_in) begin
          if (bus.bg_btn_in)     pend_bg_d  = pend_bg_q + 2'd1;
          if (bus.target_btn_in) pend_tgt_d = tgt_step(pend_tgt_q);
          if (accept) begin
            pend_bg_d  = bus.cmd_bg_in;
            pend_tgt_d = (bus.cmd_target_in == TGT_TEST) ? 2'b00 : bus.cmd_target_in;
          end
          if (btn || accept) state_d = PEND;
        end else if (state_q == PEND) begin
          if ((pend_bg_q != active_bg_q) || (pend_tgt_q != active_tgt_q)) begin
            active_bg_d  = pend_bg_q;
            active_tgt_d = pend_tgt_q;
            mc_d         = 1'b1;
            flash_cnt_d  = FLASH_LD;
            state_d      = (FLASH_LD == 8'd0) ? IDLE : FLASH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLASH: begin
        if (bus.new_frame_in) begin
          flash_cnt_d = flash_cnt_q - 8'd1;
          if (flash_cnt_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AUTO_CYCLE_EN
    idle_cnt_d = 16'd0;
    // Counts only quiet frames spent in IDLE; any user activity restarts it.
    if (state_q == IDLE && !btn && !accept && bus.new_frame_in) begin
      if (idle_cnt_q + 16'd1 == AUTO_LD) begin
        pend_bg_d = active_bg_q + 2'd1;
        state_d   = PEND;
      end else begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
    end else if (state_q == IDLE && !btn && !accept) begin
      idle_cnt_d = idle_cnt_q;
    end
`endif

    bg_d  = active_bg_d;
    tgt_d = (state_d == FLASH) ? TGT_TEST : active_tgt_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      active_bg_q  <= 2'b00;
      active_tgt_q <= 2'b00;
      pend_bg_q    <= 2'b00;
      pend_tgt_q   <= 2'b00;
      flash_cnt_q  <= 8'd0;
      bg_q         <= 2'b00;
      tgt_q        <= 2'b00;
      mc_q         <= 1'b0;
`ifdef AUTO_CYCLE_EN
      idle_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      active_bg_q  <= active_bg_d;
      active_tgt_q <= active_tgt_d;
      pend_bg_q    <= pend_bg_d;
      pend_tgt_q   <= pend_tgt_d;
      flash_cnt_q  <= flash_cnt_d;
      bg_q         <= bg_d;
      tgt_q        <= tgt_d;
      mc_q         <= mc_d;
`ifdef AUTO_CYCLE_EN
      idle_cnt_q   <= idle_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready_out   = cmd_ready;
  assign bus.bg_out          = bg_q;
  assign bus.target_out      = tgt_q;
  assign bus.mode_change_out = mc_q;
  assign bus.busy_out        = (state_q != IDLE);

endmodule

// File: doc/video_mux_ctrl.md
# video_mux_ctrl

Frame-synchronous mode controller for the video output mux. Collects mode requests from two user buttons and from the gesture pipeline's command stream. Arbitrates between them and holds them as a pending mode. Commits the pending mode only at a new-frame pulse, so background/overlay selection never changes mid-frame. After each commit it forces the overlay select to the test-colour code for a programmable number of frames as a visual acknowledgement.

## Interface
Parameters:
- FLASH_FRAMES, 4: frames of test-colour overlay after each commit; 0 disables the flash. Legal range 0–255.
- AUTO_PERIOD_FRAMES, 120: idle frames between automatic background steps; only used with the macro. Legal range 1–65535.

Ports:
- clk_in  input  1  pixel clock; single clock domain.
- rst_n_in  input  1  synchronous, active-low reset.
- new_frame_in  input  1  one-cycle pulse at the start of vertical blanking.
- bg_btn_in  input  1  one-cycle, already-debounced pulse: step background mode.
- target_btn_in  input  1  one-cycle, already-debounced pulse: step overlay mode.
- cmd_valid_in  input  1  gesture command valid.
- cmd_bg_in  input  2  commanded background mode.
- cmd_target_in  input  2  commanded overlay mode.
- cmd_ready_out  output  1  command accepted when valid and ready are both high in the same cycle.
- bg_out  output  2  background select to the mux; registered.
- target_out  output  2  overlay select to the mux; registered.
- mode_change_out  output  1  one-cycle pulse in the cycle the committed mode changes.
- busy_out  output  1  high in PEND or FLASH.

## Operation
Registers:
- active_bg and active_tgt hold the committed mode.
- pend_bg and pend_tgt hold the pending mode.

States:
- IDLE: pend equals active.
- PEND: an update is waiting for the next frame.
- FLASH: post-commit acknowledgement.

Update sources (IDLE or PEND only, and only when new_frame_in is low):
- bg_btn_in: pend_bg <= pend_bg+1, wrapping 3 to 0.
- target_btn_in: pend_tgt steps 00→01→10→00. Code 11 is reserved for the flash and never held in pend_tgt.
- Accepted command: pend_bg <= cmd_bg_in. pend_tgt <= cmd_target_in, with 11 mapped to 00.
- Arbitration: any button pulse beats a command. cmd_ready_out is low in any cycle where either button pulse is high.
- Both buttons in one cycle: both fields step.
- Any update moves IDLE→PEND.

Commit, on new_frame_in in PEND:
- If pend differs from active: active <= pend and mode_change_out pulses. The FLASH counter loads FLASH_FRAMES and the state goes to FLASH; if FLASH_FRAMES=0 it goes to IDLE instead.
- If pend equals active (for example, stepped all the way round): go to IDLE with no pulse.

In the cycle where new_frame_in is high:
- Button pulses are dropped.
- cmd_ready_out is 0.

FLASH state:
- Buttons are ignored and cmd_ready_out=0.
- Each new_frame_in decrements the counter. The new_frame_in that brings it to 0 returns the state to IDLE.

Outputs:
- bg_out is active_bg.
- target_out is 11 while in FLASH, otherwise active_tgt.
- cmd_ready_out = rst_n_in & (state≠FLASH) & ~new_frame_in & ~bg_btn_in & ~target_btn_in. This path is combinational.

Reset (rst_n_in low at a clock edge):
- All registers clear to 00 and the state goes to IDLE.
- bg_out=00, target_out=00, mode_change_out=0, busy_out=0.
- cmd_ready_out=0 while rst_n_in is low.
- Reset mid-PEND or mid-FLASH discards the pending mode and the flash.

## Timing
- A button or command accepted at edge t updates pend at t+1; busy_out rises at t+1.
- A commit on new_frame_in at edge f changes bg_out/target_out at f+1; mode_change_out is high for cycle f+1 only.
- An update arriving after the frame pulse waits for the following frame pulse. Worst-case latency is one frame plus one cycle.
- Flash: target_out=11 from f+1 until the cycle after the FLASH_FRAMES-th subsequent new_frame_in.

## Configuration
AUTO_CYCLE_EN:
- Defined:
  - A 16-bit idle counter runs in IDLE and increments on each new_frame_in.
  - The counter clears on any button pulse, accepted command, or leaving IDLE.
  - On the new_frame_in that reaches AUTO_PERIOD_FRAMES: pend_bg <= active_bg+1 with wrap, the counter clears and the state goes to PEND. The commit happens at the next frame.
- Undefined: no counter is built and the mode changes only on user input.

## Test plan
- Reset then release: bg_out=00, target_out=00, busy_out=0, cmd_ready_out=1 in the first idle cycle.
- bg_btn_in pulse mid-frame, FLASH_FRAMES=2: bg_out=01 the cycle after the next new_frame_in, with a single mode_change_out pulse. target_out=11 for exactly 2 frames, then 00.
- Same-cycle bg_btn_in and cmd_valid_in (cmd_bg_in=11): cmd_ready_out=0 and the command is held. The button commits bg=01 first. The command is accepted during flash-free IDLE and commits bg=11 at the next frame.
- Four bg_btn_in pulses within one frame: pend wraps back to 00 and the commit frame produces no mode_change_out and no flash.
- cmd_target_in=11 accepted: target_out commits to 00; a button press during FLASH is ignored.
- AUTO_CYCLE_EN with AUTO_PERIOD_FRAMES=3: after 3 idle frames bg_out steps 00→01 one frame later. A button press at frame 2 restarts the count.
